instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetches 24-bit instruction words from instruction memory, buffers them in a small in-order queue, and presents them with a valid/ready handshake to the decode stage that feeds `ControlUnit`. It produces the 4-bit `OPCODE` field that the control unit consumes. It also accepts the resolved branch redirect coming back from execute. It sits between instruction memory and decode, and is the producer side of the opcode/control interface.

## Interface
- `ADDR_W`, 8: instruction word-address width; the PC wraps modulo 2^ADDR_W.
- `DEPTH`, 2: instruction buffer entries, from 2 to 4.
- `RESET_PC`, 0: fetch address after reset.
- `Clock  in  1`: single clock; all state changes on the rising edge.
- `ResetN  in  1`: synchronous, active-low reset.
- `IMemReq  out  1`: fetch request.
- `IMemAddr  out  ADDR_W`: fetch word address, equal to the fetch PC.
- `IMemAck  in  1`: memory accepts the request; `IMemData` is valid in the same cycle.
- `IMemData  in  24`: fetched instruction word.
- `InstrValid  out  1`: buffer head is valid.
- `InstrReady  in  1`: decode accepts the head.
- `Instr  out  24`: head instruction word.
- `OPCODE  out  4`: equals `Instr[23:20]`; goes to `ControlUnit`.
- `InstrPC  out  ADDR_W`: address of the head instruction.
- `BranchTaken  in  1`: redirect strobe from execute.
- `BranchTarget  in  ADDR_W`: redirect address.

## Operation
- **FSM states:** BOOT, RUN, HALTED.
- **BOOT**
  - Entered on reset.
  - Lasts exactly one cycle with no request, then moves to RUN.
- **Fetch request**
  - `IMemReq = (state==RUN) && (count < DEPTH)`, using `count` before the current edge's update.
  - `IMemAddr` stays stable while `IMemReq` is high without an ack. The only exception is a redirect.
  - Transfer occurs when `IMemReq && IMemAck`. The word and its PC are enqueued at the tail, and the fetch PC increments by 1, wrapping from 2^ADDR_W-1 to 0.
- **Dequeue**
  - Occurs when `InstrValid && InstrReady`; the head advances.
  - Enqueue and dequeue in the same cycle leave `count` unchanged.
- **Redirect** (`BranchTaken`=1 at an edge)
  - Buffer is flushed (`count`←0) and fetch PC ← `BranchTarget`.
  - Any ack in that cycle is discarded and does not advance the PC.
  - State goes to RUN from either RUN or HALTED.
  - A dequeue in the same cycle still counts as consumed.
- **HALTED**
  - Entered when the enqueued word has opcode 4'hF (see Configuration).
  - The halt word itself is enqueued and delivered normally; the PC advances past it.
  - No requests are issued until `BranchTaken`. Draining of the buffer continues.
- **Reset values**
  - `IMemReq`=0, `IMemAddr`=`RESET_PC`, `InstrValid`=0, `Instr`=0, `OPCODE`=0, `InstrPC`=0, `count`=0, state=BOOT.
  - Reset asserted mid-transfer aborts it; buffer contents are lost.

## Timing
- Reset released at edge E0: BOOT during the cycle after E0. `IMemReq`=1 with `RESET_PC` in the next cycle.
- With an immediate ack, `InstrValid`=1 one edge later. First instruction visible 2 cycles after reset release.
- Fetch-to-decode latency is 1 cycle: a word acked in cycle N is at the head in cycle N+1 if the buffer was empty.
- Sustained throughput is 1 instruction/cycle with ack=1 and ready=1, for any `DEPTH` ≥ 2.
- Redirect:
  - `BranchTaken` in cycle N gives `InstrValid`=0 in cycle N+1.
  - In cycle N+1, `IMemReq`=1 with `IMemAddr`=`BranchTarget`.
  - First target instruction is valid in cycle N+2 if acked in N+1.
- Outputs `Instr`, `OPCODE`, `InstrPC` and `InstrValid` come from registers only. `IMemReq` comes from state and count only; it has no combinational path from `IMemAck` or `InstrReady`.

## Configuration
- Macro: `IFU_HALT_DETECT_EN`.
- **Defined:** an enqueued word with `IMemData[23:20]`==4'hF moves RUN→HALTED. If `BranchTaken` arrives in the same cycle, the redirect wins and state is RUN.
- **Undefined:** 4'hF is an ordinary opcode. HALTED is unreachable and fetching continues.

## Test plan
- **Reset/boot:** hold `ResetN`=0 for 3 cycles, `RESET_PC`=0x10, ack=1, ready=1 → `IMemReq` rises 1 cycle after release at 0x10. `InstrValid` follows, with `InstrPC`=0x10, 0x11, 0x12 on consecutive cycles.
- **Backpressure:** ready=0, ack=1, DEPTH=2 → exactly 2 words enqueued, then `IMemReq`=0. Asserting ready for 1 cycle → one dequeue, then one new request, and `count` returns to 2.
- **Wrap:** ADDR_W=8, PC=0xFE, streaming → `InstrPC` sequence is 0xFE, 0xFF, 0x00.
- **Redirect with collision:** `BranchTaken`=1 with target 0x40 in the same cycle as ack of a word at 0x05 and a dequeue → the 0x05 word is never presented. Next valid `InstrPC`=0x40.
- **Halt (macro defined):** word 0xF00000 at 0x03 → it is delivered with `OPCODE`=4'hF, no request is made for 0x04, then `BranchTaken` to 0x00 resumes fetching. With the macro undefined, 0x04 is fetched.
- **Reset mid-stream:** `ResetN`=0 while `count`=2 → the next cycle has `InstrValid`=0 and `IMemReq`=0, and all outputs are at their reset values.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, decode handshake and redirect.
// The master modport is the fetch unit; slave is memory/decode/execute.
interface instruction_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              IMemReq;
   logic [ADDR_W-1:0] IMemAddr;
   logic              IMemAck;
   logic [23:0]       IMemData;
   logic              InstrValid;
   logic              InstrReady;
   logic [23:0]       Instr;
   logic [3:0]        OPCODE;
   logic [ADDR_W-1:0] InstrPC;
   logic              BranchTaken;
   logic [ADDR_W-1:0] BranchTarget;

   modport master (
      output IMemReq, IMemAddr,
      input  IMemAck, IMemData,
      output InstrValid, Instr, OPCODE, InstrPC,
      input  InstrReady,
      input  BranchTaken, BranchTarget
   );

   modport slave (
      input  IMemReq, IMemAddr,
      output IMemAck, IMemData,
      input  InstrValid, Instr, OPCODE, InstrPC,
      output InstrReady,
      output BranchTaken, BranchTarget
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch with in-order buffer and branch redirect.
// Optional halt-on-opcode-F detection: define IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
   parameter int          ADDR_W   = 8,
   parameter int          DEPTH    = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                       Clock,
   input  logic                       ResetN,
   instruction_fetch_unit_if.master   bus
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } state_e;

   state_e                        state_q;
   logic [ADDR_W-1:0]             pc_q, pc_d;
   logic [DEPTH-1:0]              vld_q, vld_d;
   logic [DEPTH-1:0][23:0]        dat_q, dat_d;
   logic [DEPTH-1:0][ADDR_W-1:0]  ipc_q, ipc_d;
   logic                          req, enq, deq, halt_hit, placed;

   // Entry 0 is always the head, so decode outputs are plain flops.
   assign req = (state_q == RUN) && !vld_q[DEPTH-1];
   assign enq = req && bus.IMemAck;
   assign deq = vld_q[0] && bus.InstrReady;

`ifdef IFU_HALT_DETECT_EN
   assign halt_hit = enq && (bus.IMemData[23:20] == 4'hF);
`else
   assign halt_hit = 1'b0;
`endif

   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      ipc_d  = ipc_q;
      placed = 1'b0;
      if (deq) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            vld_d[i] = vld_q[i+1];
            dat_d[i] = dat_q[i+1];
            ipc_d[i] = ipc_q[i+1];
         end
         vld_d[DEPTH-1] = 1'b0;
      end
      if (enq) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!vld_d[i] && !placed) begin
               vld_d[i] = 1'b1;
               dat_d[i] = bus.IMemData;
               ipc_d[i] = pc_q;
               placed   = 1'b1;
            end
         end
      end
      if (bus.BranchTaken) begin
         vld_d = '0;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (bus.BranchTaken) begin
         pc_d = bus.BranchTarget;
      end else if (enq) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q <= BOOT;
         pc_q    <= ADDR_W'(RESET_PC);
         vld_q   <= '0;
         dat_q   <= '0;
         ipc_q   <= '0;
      end else begin
         pc_q  <= pc_d;
         vld_q <= vld_d;
         dat_q <= dat_d;
         ipc_q <= ipc_d;
         unique case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (bus.BranchTaken) begin
                  state_q <= RUN;
               end else if (halt_hit) begin
                  state_q <= HALTED;
               end
            end
            HALTED: begin
               if (bus.BranchTaken) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= BOOT;
         endcase
      end
   end

   assign bus.IMemReq    = req;
   assign bus.IMemAddr   = pc_q;
   assign bus.InstrValid = vld_q[0];
   assign bus.Instr      = dat_q[0];
   assign bus.OPCODE     = dat_q[0][23:20];
   assign bus.InstrPC    = ipc_q[0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed steps then random traffic
// checked against a queue-based reference model.
module tb_instruction_fetch_unit;

   localparam int DEPTH = 2;
`ifdef IFU_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic Clock;
   logic ResetN;

   instruction_fetch_unit_if #(.ADDR_W(8)) bus ();

   instruction_fetch_unit #(
      .ADDR_W  (8),
      .DEPTH   (DEPTH),
      .RESET_PC(32'h10)
   ) dut (
      .Clock (Clock),
      .ResetN(ResetN),
      .bus   (bus)
   );

   logic [23:0] mem [256];
   assign bus.IMemData = mem[bus.IMemAddr];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   logic [23:0] mq_d [$];
   logic [7:0]  mq_pc [$];
   logic [7:0]  m_pc;
   bit          m_boot, m_halt, m_known;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_req();
      return m_known && !m_boot && !m_halt && (mq_d.size() < DEPTH);
   endfunction

   task automatic model_check();
      if (m_known) begin
         chk("valid", bus.InstrValid, mq_d.size() != 0);
         chk("req", bus.IMemReq, exp_req());
         chk("addr", bus.IMemAddr, m_pc);
         if (mq_d.size() != 0) begin
            chk("instr", bus.Instr, mq_d[0]);
            chk("opcode", bus.OPCODE, mq_d[0][23:20]);
            chk("instr_pc", bus.InstrPC, mq_pc[0]);
         end
      end
   endtask

   task automatic model_step(input bit rn, ack, rdy, br,
                             input logic [7:0] tgt);
      bit deq, enq;
      if (!rn) begin
         mq_d.delete();
         mq_pc.delete();
         m_pc    = 8'h10;
         m_boot  = 1'b1;
         m_halt  = 1'b0;
         m_known = 1'b1;
      end else if (m_known) begin
         deq = (mq_d.size() != 0) && rdy;
         enq = exp_req() && ack;
         if (br) begin
            mq_d.delete();
            mq_pc.delete();
            m_pc   = tgt;
            m_boot = 1'b0;
            m_halt = 1'b0;
         end else begin
            if (deq) begin
               void'(mq_d.pop_front());
               void'(mq_pc.pop_front());
            end
            if (enq) begin
               mq_d.push_back(mem[m_pc]);
               mq_pc.push_back(m_pc);
               if (HALT_EN && mem[m_pc][23:20] == 4'hF) m_halt = 1'b1;
               m_pc = m_pc + 8'd1;
            end
            m_boot = 1'b0;
         end
      end
   endtask

   task automatic cyc(input bit rn, ack, rdy, br,
                      input logic [7:0] tgt);
      ResetN           = rn;
      bus.IMemAck      = ack;
      bus.InstrReady   = rdy;
      bus.BranchTaken  = br;
      bus.BranchTarget = tgt;
      model_check();
      model_step(rn, ack, rdy, br, tgt);
      @(posedge Clock);
      @(negedge Clock);
   endtask

   initial begin
      logic [23:0] w;
      int          a;
      m_known = 1'b0;
      m_boot  = 1'b0;
      m_halt  = 1'b0;
      m_pc    = 8'h00;
      for (int i = 0; i < 256; i++) begin
         w = 24'($urandom);
         if (w[23:20] == 4'hF) w[23:20] = 4'hE;
         mem[i] = w;
      end
      mem[3] = 24'hF00000;
      ResetN           = 1'b0;
      bus.IMemAck      = 1'b0;
      bus.InstrReady   = 1'b0;
      bus.BranchTaken  = 1'b0;
      bus.BranchTarget = 8'h00;
      @(negedge Clock);

      // reset and boot
      repeat (3) cyc(0, 1, 1, 0, 8'h00);
      chk("rst_req", bus.IMemReq, 1'b0);
      chk("rst_addr", bus.IMemAddr, 8'h10);
      chk("rst_valid", bus.InstrValid, 1'b0);
      chk("rst_instr", bus.Instr, 24'h0);
      chk("rst_opcode", bus.OPCODE, 4'h0);
      chk("rst_ipc", bus.InstrPC, 8'h00);
      cyc(1, 1, 1, 0, 8'h00);
      chk("boot_req", bus.IMemReq, 1'b1);
      chk("boot_addr", bus.IMemAddr, 8'h10);
      cyc(1, 1, 1, 0, 8'h00);
      chk("first_valid", bus.InstrValid, 1'b1);
      chk("first_pc", bus.InstrPC, 8'h10);
      cyc(1, 1, 1, 0, 8'h00);
      chk("second_pc", bus.InstrPC, 8'h11);
      cyc(1, 1, 1, 0, 8'h00);
      chk("third_pc", bus.InstrPC, 8'h12);

      // backpressure
      repeat (3) cyc(1, 1, 0, 0, 8'h00);
      chk("bp_full_req", bus.IMemReq, 1'b0);
      chk("bp_full_valid", bus.InstrValid, 1'b1);
      cyc(1, 0, 1, 0, 8'h00);
      chk("bp_one_slot_req", bus.IMemReq, 1'b1);
      cyc(1, 1, 0, 0, 8'h00);
      chk("bp_refill_req", bus.IMemReq, 1'b0);

      // wrap
      cyc(1, 1, 1, 1, 8'hFE);
      chk("wrap_flush", bus.InstrValid, 1'b0);
      chk("wrap_addr", bus.IMemAddr, 8'hFE);
      cyc(1, 1, 1, 0, 8'h00);
      chk("wrap_pc0", bus.InstrPC, 8'hFE);
      cyc(1, 1, 1, 0, 8'h00);
      chk("wrap_pc1", bus.InstrPC, 8'hFF);
      cyc(1, 1, 1, 0, 8'h00);
      chk("wrap_pc2", bus.InstrPC, 8'h00);

      // redirect colliding with ack and dequeue
      cyc(1, 1, 1, 1, 8'h04);
      cyc(1, 1, 1, 0, 8'h00);
      chk("col_head", bus.InstrPC, 8'h04);
      chk("col_addr", bus.IMemAddr, 8'h05);
      cyc(1, 1, 1, 1, 8'h40);
      chk("col_flush", bus.InstrValid, 1'b0);
      chk("col_req", bus.IMemReq, 1'b1);
      chk("col_addr_tgt", bus.IMemAddr, 8'h40);
      cyc(1, 1, 1, 0, 8'h00);
      chk("col_tgt_pc", bus.InstrPC, 8'h40);

      // halt word at 0x03
      cyc(1, 1, 1, 1, 8'h02);
      cyc(1, 1, 1, 0, 8'h00);
      cyc(1, 1, 1, 0, 8'h00);
      chk("halt_pc", bus.InstrPC, 8'h03);
      chk("halt_opcode", bus.OPCODE, 4'hF);
      chk("halt_addr", bus.IMemAddr, 8'h04);
      chk("halt_req", bus.IMemReq, !HALT_EN);
      cyc(1, 1, 1, 0, 8'h00);
      chk("halt_next_valid", bus.InstrValid, !HALT_EN);
      cyc(1, 1, 1, 0, 8'h00);
      chk("halt_stay_req", bus.IMemReq, !HALT_EN);
      cyc(1, 1, 1, 1, 8'h00);
      chk("resume_req", bus.IMemReq, 1'b1);
      chk("resume_addr", bus.IMemAddr, 8'h00);

      // reset while buffer full
      repeat (3) cyc(1, 1, 0, 0, 8'h00);
      chk("mid_full_req", bus.IMemReq, 1'b0);
      cyc(0, 1, 0, 0, 8'h00);
      chk("mid_valid", bus.InstrValid, 1'b0);
      chk("mid_req", bus.IMemReq, 1'b0);
      chk("mid_instr", bus.Instr, 24'h0);
      chk("mid_opcode", bus.OPCODE, 4'h0);
      chk("mid_ipc", bus.InstrPC, 8'h00);
      chk("mid_addr", bus.IMemAddr, 8'h10);

      // random traffic, with some halt words sprinkled in
      for (int i = 0; i < 12; i++) begin
         a = $urandom_range(0, 255);
         w = 24'($urandom);
         w[23:20] = 4'hF;
         mem[a] = w;
      end
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 199) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0,
             8'($urandom_range(0, 255)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
